// File: rtl/trena_pkg.sv
// Shared definitions for the trena control unit: state encodings shown on the
// debug display, message length and the default measurement watchdog.
package trena_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        MEDE           = 4'd2,
        AGUARDA_MEDIDA = 4'd3,
        TRANSMITE      = 4'd4,
        AGUARDA_TX     = 4'd5,
        PROXIMO        = 4'd6,
        FINAL          = 4'd7,
        ERRO           = 4'd15
    } estado_t;

    localparam int NUM_CARACTERES = 4;

    // 60 ms at 50 MHz
    localparam int TIMEOUT_PADRAO = 3_000_000;

endpackage

// File: rtl/contador_m.sv
// Saturating modulo-M counter used as the measurement watchdog.
// It is cleared synchronously, advances while enabled and holds at M-1.
module contador_m #(
    parameter int M = 100,
    parameter int N = $clog2(M)
) (
    input  logic clock,
    input  logic reset,
    input  logic zera_s,
    input  logic conta,
    output logic fim
);

    localparam logic [N-1:0] ULTIMO    = N'(M - 1);
    localparam logic [N-1:0] PENULTIMO = N'(M - 2);

    logic [N-1:0] valor;

    always_ff @(posedge clock) begin
        if (reset || zera_s) begin
            valor <= '0;
        end else if (conta && (valor != ULTIMO)) begin
            valor <= valor + 1'b1;
        end
    end

    // fim flags the cycle in which the count steps onto M-1, so the caller
    // sees the terminal count without an extra cycle of latency.
    assign fim = (valor == ULTIMO) || (conta && (valor == PENULTIMO));

endmodule

// File: rtl/exp4_trena_uc.sv
// Control unit for the ultrasonic tape measure: triggers one measurement,
// sends the result as ASCII characters over the serial link, and aborts on a missing echo.
module exp4_trena_uc
    import trena_pkg::*;
#(
    parameter int TIMEOUT_MEDIDA = TIMEOUT_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mensurar,
    input  logic       pronto_medida,
    input  logic       pronto_transmissao,
    input  logic       fim_serial,
    output logic       zera,
    output logic       medir,
    output logic       partida_serial,
    output logic       conta_ascii,
    output logic       pronto,
    output logic       erro,
    output logic [3:0] db_estado
);

    localparam int N_WATCHDOG = $clog2(TIMEOUT_MEDIDA);

    estado_t estado;
    estado_t proximo;
    logic    zera_watchdog;
    logic    conta_watchdog;
    logic    fim_watchdog;

    assign zera_watchdog  = (estado == PREPARA);
    assign conta_watchdog = (estado == AGUARDA_MEDIDA);

    contador_m #(
        .M (TIMEOUT_MEDIDA),
        .N (N_WATCHDOG)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .zera_s (zera_watchdog),
        .conta  (conta_watchdog),
        .fim    (fim_watchdog)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // erro survives the return to INICIAL so the operator can still see it;
    // only accepting a new cycle clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            erro <= 1'b0;
        end else if (estado == ERRO) begin
            erro <= 1'b1;
        end else if (estado == PREPARA) begin
            erro <= 1'b0;
        end
    end

    always_comb begin
        proximo        = INICIAL;
        zera           = 1'b0;
        medir          = 1'b0;
        partida_serial = 1'b0;
        conta_ascii    = 1'b0;
        pronto         = 1'b0;
        case (estado)
            INICIAL:        proximo = mensurar ? PREPARA : INICIAL;
            PREPARA: begin
                zera    = 1'b1;
                proximo = MEDE;
            end
            MEDE: begin
                medir   = 1'b1;
                proximo = AGUARDA_MEDIDA;
            end
            // A measurement arriving on the terminal cycle still counts.
            AGUARDA_MEDIDA: begin
                if (pronto_medida) begin
                    proximo = TRANSMITE;
                end else if (fim_watchdog) begin
                    proximo = ERRO;
                end else begin
                    proximo = AGUARDA_MEDIDA;
                end
            end
            TRANSMITE: begin
                partida_serial = 1'b1;
                proximo        = AGUARDA_TX;
            end
            AGUARDA_TX: begin
                if (pronto_transmissao) begin
                    proximo = fim_serial ? FINAL : PROXIMO;
                end else begin
                    proximo = AGUARDA_TX;
                end
            end
            PROXIMO: begin
                conta_ascii = 1'b1;
                proximo     = TRANSMITE;
            end
            FINAL: begin
                pronto  = 1'b1;
                proximo = INICIAL;
            end
            ERRO:           proximo = INICIAL;
            default:        proximo = INICIAL;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_exp4_trena_uc.sv
// Self-checking bench for exp4_trena_uc: drives randomized sensor/serial latencies
// and checks pulse counts and cycle timing against a cycle-arithmetic model.
module tb_exp4_trena_uc;

    localparam int TIMEOUT = 100;

    logic       clock;
    logic       reset;
    logic       mensurar;
    logic       pronto_medida;
    logic       pronto_transmissao;
    logic       fim_serial;
    logic       zera;
    logic       medir;
    logic       partida_serial;
    logic       conta_ascii;
    logic       pronto;
    logic       erro;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int n_zera, n_medir, n_partida, n_conta, n_pronto;
    int c_zera, c_zera_segundo, c_medir, c_partida, c_partida_primeiro, c_pronto, c_erro_estado;
    int echo_delay, tx_delay, idx;
    bit any_active;

    exp4_trena_uc #(
        .TIMEOUT_MEDIDA (TIMEOUT)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .mensurar           (mensurar),
        .pronto_medida      (pronto_medida),
        .pronto_transmissao (pronto_transmissao),
        .fim_serial         (fim_serial),
        .zera               (zera),
        .medir              (medir),
        .partida_serial     (partida_serial),
        .conta_ascii        (conta_ascii),
        .pronto             (pronto),
        .erro               (erro),
        .db_estado          (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_timeout: observed still running expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic reset_model();
        n_zera = 0; n_medir = 0; n_partida = 0; n_conta = 0; n_pronto = 0;
        c_zera = -1; c_zera_segundo = -1; c_medir = -1; c_partida = -1;
        c_partida_primeiro = -1; c_pronto = -1; c_erro_estado = -1;
        idx = 0;
    endtask

    // One clock: observe the DUT mid-cycle, then play the sensor, the serial
    // transmitter and the character-index register of the datapath.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (zera || medir || partida_serial || conta_ascii || pronto) any_active = 1'b1;
        if (zera) begin
            n_zera++;
            if (n_zera == 1) c_zera = cyc;
            if (n_zera == 2) c_zera_segundo = cyc;
        end
        if (medir) begin
            n_medir++;
            c_medir = cyc;
        end
        if (partida_serial) begin
            n_partida++;
            c_partida = cyc;
            if (n_partida == 1) c_partida_primeiro = cyc;
        end
        if (conta_ascii) n_conta++;
        if (pronto) begin
            n_pronto++;
            if (n_pronto == 1) c_pronto = cyc;
        end
        if (db_estado == 4'd15 && c_erro_estado < 0) c_erro_estado = cyc;
        pronto_medida      = (echo_delay > 0 && c_medir >= 0 && cyc == c_medir + echo_delay);
        pronto_transmissao = (c_partida >= 0 && cyc == c_partida + tx_delay);
        fim_serial         = (idx == 3);
        if (conta_ascii) idx++;
        if (zera) idx = 0;
    endtask

    task automatic check_output(input string tag, input logic signed [31:0] observed,
                                input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int d_echo, input int d_tx);
        echo_delay = d_echo;
        tx_delay   = d_tx;
        mensurar   = 1'b1;
        step();
        mensurar   = 1'b0;
    endtask

    task automatic run_until_pronto(input int count, input int budget);
        for (int i = 0; i < budget && n_pronto < count; i++) step();
    endtask

    initial begin
        int k, d, t, partidas_antes;

        reset = 1'b1; mensurar = 1'b0; pronto_medida = 1'b0;
        pronto_transmissao = 1'b0; fim_serial = 1'b0;
        echo_delay = -1; tx_delay = 10; any_active = 1'b0;
        reset_model();

        // Reset and idle
        step(); step();
        check_output("reset_estado", 32'(db_estado), 0);
        check_output("reset_erro", 32'(erro), 0);
        check_output("reset_saidas", 32'({zera, medir, partida_serial, conta_ascii, pronto}), 0);
        reset = 1'b0;
        any_active = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check_output("idle_saidas", 32'(any_active), 0);
        check_output("idle_estado", 32'(db_estado), 0);
        check_output("idle_erro", 32'(erro), 0);

        // Normal cycles with random latencies
        for (int r = 0; r < 3; r++) begin
            d = (r == 0) ? 30 : int'($urandom_range(98, 1));
            t = (r == 0) ? 10 : int'($urandom_range(12, 1));
            reset_model();
            k = cyc;
            apply_stimulus(d, t);
            run_until_pronto(1, 2000);
            check_output("normal_zera_tempo", c_zera, k + 1);
            check_output("normal_medir_tempo", c_medir, k + 2);
            check_output("normal_n_zera", n_zera, 1);
            check_output("normal_n_medir", n_medir, 1);
            check_output("normal_primeira_partida", c_partida_primeiro, c_medir + d + 1);
            check_output("normal_n_partida", n_partida, 4);
            check_output("normal_n_conta", n_conta, 3);
            check_output("normal_n_pronto", n_pronto, 1);
            check_output("normal_pronto_tempo", c_pronto, c_medir + d + 1 + 3 * (t + 2) + t + 1);
            check_output("normal_erro", 32'(erro), 0);
            step();
            check_output("normal_volta_inicial", 32'(db_estado), 0);
            step(); step();
        end

        // No echo: watchdog expires
        reset_model();
        apply_stimulus(-1, 10);
        for (int i = 0; i < 400 && c_erro_estado < 0; i++) step();
        check_output("timeout_estado_tempo", c_erro_estado, c_medir + TIMEOUT);
        check_output("timeout_erro_ainda_baixo", 32'(erro), 0);
        step();
        check_output("timeout_erro_sobe", 32'(erro), 1);
        check_output("timeout_volta_inicial", 32'(db_estado), 0);
        for (int i = 0; i < 5; i++) step();
        check_output("timeout_erro_mantido", 32'(erro), 1);
        check_output("timeout_sem_partida", n_partida, 0);

        // A new request clears erro once PREPARA is taken
        apply_stimulus(20, 3);
        check_output("limpa_prepara_estado", 32'(db_estado), 1);
        step();
        check_output("limpa_erro", 32'(erro), 0);
        run_until_pronto(1, 2000);
        check_output("limpa_n_pronto", n_pronto, 1);
        check_output("limpa_erro_final", 32'(erro), 0);
        step(); step();

        // pronto_medida on the watchdog terminal cycle
        reset_model();
        apply_stimulus(TIMEOUT - 1, 2);
        run_until_pronto(1, 2000);
        check_output("coincide_partida_tempo", c_partida_primeiro, c_medir + TIMEOUT);
        check_output("coincide_sem_erro_estado", c_erro_estado, -1);
        check_output("coincide_erro", 32'(erro), 0);
        check_output("coincide_n_partida", n_partida, 4);
        step(); step();

        // Reset while waiting for the third character
        reset_model();
        apply_stimulus(5, 20);
        for (int i = 0; i < 500 && n_partida < 3; i++) step();
        step(); step();
        check_output("tx_espera_estado", 32'(db_estado), 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        any_active = 1'b0;
        step();
        check_output("tx_reset_estado", 32'(db_estado), 0);
        check_output("tx_reset_erro", 32'(erro), 0);
        partidas_antes = n_partida;
        for (int i = 0; i < 30; i++) step();
        check_output("tx_reset_saidas", 32'(any_active), 0);
        check_output("tx_reset_estado_final", 32'(db_estado), 0);
        check_output("tx_reset_sem_partida", n_partida, partidas_antes);

        // mensurar held high: back-to-back cycles
        reset_model();
        d = int'($urandom_range(98, 1));
        t = int'($urandom_range(12, 1));
        echo_delay = d;
        tx_delay   = t;
        mensurar   = 1'b1;
        run_until_pronto(2, 4000);
        mensurar   = 1'b0;
        check_output("seguido_n_pronto", n_pronto, 2);
        check_output("seguido_zera_tempo", c_zera_segundo, c_pronto + 2);
        check_output("seguido_n_partida", n_partida, 8);
        check_output("seguido_n_conta", n_conta, 6);
        for (int i = 0; i < 10; i++) step();
        check_output("seguido_n_zera", n_zera, 2);
        check_output("seguido_estado_final", 32'(db_estado), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp4_trena_uc.md
# exp4_trena_uc

Control unit for the ultrasonic tape-measure ("trena") datapath. On a start request it triggers one HC-SR04 measurement and waits for the result. It then transmits the result over the 7E1 serial transmitter as four ASCII characters: three hex digits, MSB nibble first, followed by a separator. It drives the datapath's `medir`, `zera`, `conta_ascii` and `partida_serial` controls, and runs a watchdog so that a missing echo aborts the cycle instead of hanging.

## Interface
Parameters:
- `TIMEOUT_MEDIDA`, default 3_000_000: cycles allowed between the `medir` pulse and `pronto_medida`; 60 ms at 50 MHz.

Ports:
- `clock` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mensurar` in 1: start request; level, sampled only in `INICIAL`.
- `pronto_medida` in 1: 1-cycle pulse from the sensor interface; measurement valid.
- `pronto_transmissao` in 1: 1-cycle pulse from the serial transmitter; character sent.
- `fim_serial` in 1: datapath character index is at the last character (index 3).
- `zera` out 1: clears the datapath character index.
- `medir` out 1: 1-cycle measurement trigger.
- `partida_serial` out 1: 1-cycle transmit start.
- `conta_ascii` out 1: advances the character index.
- `pronto` out 1: 1-cycle pulse; cycle completed successfully.
- `erro` out 1: sticky timeout flag.
- `db_estado` out 4: current state encoding, for 7-segment debug.

## Operation
Moore FSM. All control outputs are decoded from the state only. States, with encodings and transitions:
- `INICIAL` (0): idle. If `mensurar`=1, go to `PREPARA`.
- `PREPARA` (1): `zera`=1; clear the watchdog counter; clear `erro`. Go to `MEDE`.
- `MEDE` (2): `medir`=1. Go to `AGUARDA_MEDIDA`.
- `AGUARDA_MEDIDA` (3): watchdog counts every cycle.
  - If `pronto_medida`=1, go to `TRANSMITE`.
  - Else if the watchdog reaches `TIMEOUT_MEDIDA`-1, go to `ERRO`.
- `TRANSMITE` (4): `partida_serial`=1. Go to `AGUARDA_TX`.
- `AGUARDA_TX` (5): wait for `pronto_transmissao`=1.
  - If `fim_serial`=1, go to `FINAL`.
  - Else go to `PROXIMO`.
- `PROXIMO` (6): `conta_ascii`=1. Go to `TRANSMITE`.
- `FINAL` (7): `pronto`=1. Go to `INICIAL`.
- `ERRO` (15): set `erro`=1. Go to `INICIAL`.

Further rules:
- `erro` is a registered flag. It is set in `ERRO` and cleared only in `PREPARA`, i.e. when the next cycle is accepted. It is held through `INICIAL` in between.
- `pronto_medida` and `pronto_transmissao` are ignored outside their wait states.
- If `pronto_medida` and the watchdog terminal count coincide, `pronto_medida` wins.
- The watchdog is a counter of width `$clog2(TIMEOUT_MEDIDA)`. It saturates and never wraps.
- `mensurar` held high causes back-to-back cycles; `INICIAL` lasts exactly one cycle in between.
- Reset behaviour:
  - Reset in any state gives next state `INICIAL`.
  - All control outputs are 0, `erro`=0, watchdog=0, `db_estado`=0.
  - Reset in mid-transmission does not wait for `pronto_transmissao`.
- Unused encodings go to `INICIAL`.

## Timing
- Measurement start:
  - `mensurar` sampled at edge k gives `zera` during cycle k+1.
  - `medir` is asserted during cycle k+2.
- Serial start: `partida_serial` asserts the cycle after the `pronto_medida` pulse is sampled.
- Per character after the first: the `pronto_transmissao` sample is followed by `conta_ascii` for 1 cycle, then `partida_serial` for 1 cycle.
- End of message: the 4th `pronto_transmissao` (with `fim_serial`=1) is followed by `pronto` in the next cycle. The total message is exactly 4 `partida_serial` pulses and 3 `conta_ascii` pulses.
- Timeout:
  - `medir` is in cycle m; `ERRO` is entered at cycle m+`TIMEOUT_MEDIDA`.
  - `erro` rises in the following cycle.
  - No `partida_serial` is issued on a timeout.
- Every control output is high for at most one cycle per state visit.

## Structure
- Package `trena_pkg`:
  - state enum with the 4-bit encodings above;
  - `NUM_CARACTERES` = 4;
  - default timeout constant.
- One sub-module: the watchdog, implemented by the existing `contador_m`, with M=`TIMEOUT_MEDIDA` and N=`$clog2(TIMEOUT_MEDIDA)`.
  - `zera_s` is driven from `PREPARA`.
  - `conta` is driven from `AGUARDA_MEDIDA`.
  - `fim` is the timeout.
- Next-state logic, state register and output decode live in this module.

## Test plan
All scenarios use `TIMEOUT_MEDIDA`=100.
- Reset, then hold `mensurar`=0 for 20 cycles: all outputs stay 0 and `db_estado`=0.
- Normal cycle: pulse `mensurar`, return `pronto_medida` 30 cycles after `medir`, and answer each `partida_serial` with `pronto_transmissao` 10 cycles later, `fim_serial`=1 on the 4th character.
  - Required: exactly 1 `zera`, 1 `medir`, 4 `partida_serial`, 3 `conta_ascii`, then 1 `pronto`, with `erro`=0.
- No echo: `pronto_medida` is never asserted.
  - Required: `db_estado`=15 exactly 100 cycles after `medir`; `erro`=1 thereafter; no `partida_serial`.
  - A following `mensurar` clears `erro` in the `PREPARA` cycle.
- Coincidence: `pronto_medida` arrives in the watchdog terminal cycle.
  - Required: transition to `TRANSMITE`; `erro` stays 0.
- Reset in `AGUARDA_TX` after 2 characters.
  - Required: next cycle `db_estado`=0 and all outputs are 0; a late `pronto_transmissao` is ignored.
- `mensurar` held high through 2 full cycles: a second `zera` occurs exactly 2 cycles after the first `pronto`.
